mmio_led_pwm: RTL and testbench

Memory-mapped LED/RGB peripheral that answers the core's load/store data-bus requests and drives the board `LED`, `RGB_R`, `RGB_G` and `RGB_B` pins. It sits beside data memory in `top`, decodes its own address window, and returns read data for `lw`. It latches `sw` data into duty registers that feed three glitch-free 8-bit PWM channels.

---
 rtl/mmio_led_pwm.sv | 167 ++++++++++++++++
 tb/tb_mmio_led_pwm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_led_pwm.sv
// Memory-mapped LED/RGB peripheral: CTRL, DUTY_R/G/B, PRESC and TIMER registers
// feeding three shadow-updated 8-bit PWM channels. Optional: MMIO_LED_PWM_TIMER_EN.
module mmio_led_pwm #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter logic [15:0] PRESC_RESET = 16'd46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        LED,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B
);

  logic        hit;
  logic        wr;
  logic [5:0]  off;

  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  dr_q, dr_d;
  logic [7:0]  dg_q, dg_d;
  logic [7:0]  db_q, db_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] psc_q, psc_d;
  logic [7:0]  pwm_q, pwm_d;
  logic [7:0]  ar_q, ar_d;
  logic [7:0]  ag_q, ag_d;
  logic [7:0]  ab_q, ab_d;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  rgb_q, rgb_d;
  logic [31:0] rd_mux;
  logic        en;
  logic        tick;
  logic        wrap;
  logic        presc_wr;
  logic        timer_wr;
  logic [31:0] timer_val;

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16], wmask[3:2], timer_wr};

  assign hit = req && (addr[31:8] == BASE_ADDR[31:8]);
  assign wr  = hit && we;
  assign off = addr[7:2];

  assign presc_wr = wr && (off == 6'h04);
  assign timer_wr = wr && (off == 6'h05);

`ifdef MMIO_LED_PWM_TIMER_EN
  logic [31:0] timer_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= 32'd0;
    end else if (timer_wr) begin
      timer_q <= 32'd0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timer_val = timer_q;
`else
  assign timer_val = 32'd0;
`endif

  always_comb begin
    ctrl_d  = ctrl_q;
    dr_d    = dr_q;
    dg_d    = dg_q;
    db_d    = db_q;
    presc_d = presc_q;
    if (wr) begin
      unique case (off)
        6'h00: if (wmask[0]) ctrl_d = wdata[1:0];
        6'h01: if (wmask[0]) dr_d = wdata[7:0];
        6'h02: if (wmask[0]) dg_d = wdata[7:0];
        6'h03: if (wmask[0]) db_d = wdata[7:0];
        6'h04: begin
          if (wmask[0]) presc_d[7:0]  = wdata[7:0];
          if (wmask[1]) presc_d[15:8] = wdata[15:8];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    unique case (off)
      6'h00:   rd_mux = {30'd0, ctrl_q};
      6'h01:   rd_mux = {24'd0, dr_q};
      6'h02:   rd_mux = {24'd0, dg_q};
      6'h03:   rd_mux = {24'd0, db_q};
      6'h04:   rd_mux = {16'd0, presc_q};
      6'h05:   rd_mux = timer_val;
      default: rd_mux = 32'd0;
    endcase
    rdata_d = (hit && !we) ? rd_mux : 32'd0;
  end

  // Disabled: counters parked at 0, active duties follow DUTY every cycle.
  always_comb begin
    en    = ctrl_q[1];
    tick  = en && (psc_q == presc_q);
    wrap  = tick && (pwm_q == 8'hFF);
    psc_d = (!en || presc_wr || tick) ? 16'd0 : psc_q + 16'd1;
    pwm_d = !en ? 8'd0 : (tick ? pwm_q + 8'd1 : pwm_q);
    ar_d  = (!en || wrap) ? dr_d : ar_q;
    ag_d  = (!en || wrap) ? dg_d : ag_q;
    ab_d  = (!en || wrap) ? db_d : ab_q;
    rgb_d = 3'b111;
    if (ctrl_d[1]) begin
      rgb_d[0] = !(pwm_d < ar_d);
      rgb_d[1] = !(pwm_d < ag_d);
      rgb_d[2] = !(pwm_d < ab_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= 2'd0;
      dr_q    <= 8'd0;
      dg_q    <= 8'd0;
      db_q    <= 8'd0;
      presc_q <= PRESC_RESET;
      psc_q   <= 16'd0;
      pwm_q   <= 8'd0;
      ar_q    <= 8'd0;
      ag_q    <= 8'd0;
      ab_q    <= 8'd0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      rgb_q   <= 3'b111;
    end else begin
      ctrl_q  <= ctrl_d;
      dr_q    <= dr_d;
      dg_q    <= dg_d;
      db_q    <= db_d;
      presc_q <= presc_d;
      psc_q   <= psc_d;
      pwm_q   <= pwm_d;
      ar_q    <= ar_d;
      ag_q    <= ag_d;
      ab_q    <= ab_d;
      ack_q   <= hit;
      rdata_q <= rdata_d;
      rgb_q   <= rgb_d;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign LED   = ctrl_q[0];
  assign RGB_R = rgb_q[0];
  assign RGB_G = rgb_q[1];
  assign RGB_B = rgb_q[2];

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Directed self-checking bench for mmio_led_pwm.
// Honors MMIO_LED_PWM_TIMER_EN for the TIMER expectations.
module tb_mmio_led_pwm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wmask = 4'd0;
  logic [31:0] rdata;
  logic        ack;
  logic        LED;
  logic        RGB_R, RGB_G, RGB_B;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] B = 32'hFFFF_FF00;

  mmio_led_pwm dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .wmask(wmask),
    .rdata(rdata), .ack(ack), .LED(LED),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lw(input logic [31:0] a, output logic [31:0] d, output logic k);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = rdata; k = ack;
    req = 1'b0;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; wmask = m;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  // Samples at negedges until RGB_R goes 1 -> 0 (start of a PWM period).
  task automatic wait_fall(output logic ok);
    logic prev;
    ok = 1'b0;
    prev = RGB_R;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (prev && !RGB_R) begin
        ok = 1'b1;
        break;
      end
      prev = RGB_R;
    end
  endtask

  initial begin
    logic [31:0] d, t0, t1;
    logic        k, ok;
    int          nr, ng, nb;

    repeat (3) @(negedge clk);
    chk("rst_led", {31'd0, LED}, 32'd0);
    chk("rst_rgb", {29'd0, RGB_B, RGB_G, RGB_R}, 32'h7);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_rdata", rdata, 32'd0);

    lw(B + 32'h10, d, k);
    chk("presc_ack", {31'd0, k}, 32'd1);
    chk("presc_rst", d, 32'd46);
    chk("idle_ack", {31'd0, ack}, 32'd1);
    @(negedge clk);
    chk("ack_one", {31'd0, ack}, 32'd0);

    sw(B + 32'h10, 32'h0000_AB00, 4'b0010);
    lw(B + 32'h10, d, k);
    chk("presc_mask", d, 32'h0000_AB2E);

    sw(B, 32'h3, 4'hF);
    chk("led_on", {31'd0, LED}, 32'd1);
    lw(B, d, k);
    chk("ctrl_rd", d, 32'h3);
    lw(B + 32'h40, d, k);
    chk("hole_ack", {31'd0, k}, 32'd1);
    chk("hole_rd", d, 32'd0);
    lw(32'h0000_0100, d, k);
    chk("miss_ack", {31'd0, k}, 32'd0);
    chk("miss_rd", d, 32'd0);

    sw(B + 32'h04, 32'hFFFF_FF40, 4'hF);
    lw(B + 32'h04, d, k);
    chk("duty_wide", d, 32'h40);

    // Back-to-back loads: one ack per cycle.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = B;
    @(negedge clk);
    chk("b2b_ack0", {31'd0, ack}, 32'd1);
    chk("b2b_rd0", rdata, 32'h3);
    addr = B + 32'h04;
    @(negedge clk);
    req = 1'b0;
    chk("b2b_ack1", {31'd0, ack}, 32'd1);
    chk("b2b_rd1", rdata, 32'h40);

    sw(B, 32'h1, 4'hF);
    sw(B + 32'h08, 32'd10, 4'hF);
    sw(B + 32'h10, 32'd0, 4'hF);
    chk("rgb_dis", {29'd0, RGB_B, RGB_G, RGB_R}, 32'h7);
    sw(B, 32'h3, 4'hF);

    nr = 0; ng = 0; nb = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      nr += RGB_R ? 0 : 1;
      ng += RGB_G ? 0 : 1;
      nb += RGB_B ? 0 : 1;
    end
    chk("r_low64", nr, 64);
    chk("g_low10", ng, 10);
    chk("b_low0", nb, 0);

    wait_fall(ok);
    chk("fall0_seen", {31'd0, ok}, 32'd1);
    repeat (100) @(negedge clk);
    sw(B + 32'h08, 32'd200, 4'h1);
    ng = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!RGB_R && i > 0 && ok) break;
      ok = RGB_R;
      ng += RGB_G ? 0 : 1;
    end
    chk("g_keep_old", ng, 0);
    ng = 0;
    for (int i = 0; i < 256; i++) begin
      ng += RGB_G ? 0 : 1;
      @(negedge clk);
    end
    chk("g_low200", ng, 200);

    lw(B + 32'h14, t0, k);
    repeat (8) @(negedge clk);
    lw(B + 32'h14, t1, k);
`ifdef MMIO_LED_PWM_TIMER_EN
    chk("timer_diff", t1 - t0, 32'd10);
    sw(B + 32'h14, 32'h1234_5678, 4'hF);
    lw(B + 32'h14, d, k);
    chk("timer_clr", {31'd0, (d <= 32'd2)}, 32'd1);
`else
    chk("timer_off0", t0, 32'd0);
    chk("timer_off1", t1, 32'd0);
`endif

    // Reset during a pending ack clears everything at once.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = B;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("pend_ack", {31'd0, ack}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_ack", {31'd0, ack}, 32'd0);
    chk("mid_led", {31'd0, LED}, 32'd0);
    chk("mid_rgb", {29'd0, RGB_B, RGB_G, RGB_R}, 32'h7);
    chk("mid_rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
